// File: rtl/dp_ctrl.sv
// dp_ctrl: top-level controller of the ECC scalar point multiplier, R = k*P via
// MSB-first double-and-add over an external point unit (op_start/op_done handshake).
module dp_ctrl #(
  parameter int DATA_WIDTH = 256,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] Px,
  input  logic [DATA_WIDTH-1:0] Py,
  input  logic [DATA_WIDTH-1:0] k,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] Rx,
  output logic [DATA_WIDTH-1:0] Ry,
  output logic                  op_start,
  output logic                  op_sel,
  output logic [DATA_WIDTH-1:0] op_ax,
  output logic [DATA_WIDTH-1:0] op_ay,
  output logic [DATA_WIDTH-1:0] op_bx,
  output logic [DATA_WIDTH-1:0] op_by,
  input  logic                  op_done,
  input  logic [DATA_WIDTH-1:0] op_rx,
  input  logic [DATA_WIDTH-1:0] op_ry,
  input  logic                  op_rinf
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DBL   = 3'd2,
    ST_DBL_W = 3'd3,
    ST_ADD   = 3'd4,
    ST_ADD_W = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  function automatic logic [IDX_W-1:0] msb_index(input logic [DATA_WIDTH-1:0] v);
    logic [IDX_W-1:0] m;
    m = {IDX_W{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (v[i]) m = IDX_W'(i);
    end
    return m;
  endfunction

  state_t                state_r, state_s;
  logic [DATA_WIDTH-1:0] p_x_r, p_y_r, k_r;
  logic [DATA_WIDTH-1:0] r_x_r, r_y_r, r_x_s, r_y_s;
  logic                  r_inf_r, r_inf_s;
  logic [IDX_W-1:0]      idx_r, idx_s, msb_s;
  logic                  bit_test_s, take_next_s;
  logic                  op_start_s, op_sel_s;
  logic                  out_valid_r, op_start_r, op_sel_r;
  logic [DATA_WIDTH-1:0] rx_r, ry_r, op_ax_r, op_ay_r, op_bx_r, op_by_r;

  assign msb_s     = msb_index(k_r);
  assign out_valid = out_valid_r;
  assign Rx        = rx_r;
  assign Ry        = ry_r;
  assign op_start  = op_start_r;
  assign op_sel    = op_sel_r;
  assign op_ax     = op_ax_r;
  assign op_ay     = op_ay_r;
  assign op_bx     = op_bx_r;
  assign op_by     = op_by_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state and accumulator update; bit test and NEXT are shared tails of the case
  always_comb begin
    state_s     = state_r;
    r_x_s       = r_x_r;
    r_y_s       = r_y_r;
    r_inf_s     = r_inf_r;
    idx_s       = idx_r;
    bit_test_s  = 1'b0;
    take_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_s = ST_LOAD;
        else          state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (k_r == {DATA_WIDTH{1'b0}}) begin
          r_inf_s = 1'b1;
          state_s = ST_DONE;
        end else begin
          r_x_s   = p_x_r;
          r_y_s   = p_y_r;
          r_inf_s = 1'b0;
          if (msb_s == {IDX_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            idx_s   = msb_s - IDX_W'(1);
            state_s = ST_DBL;
          end
        end
      end
      ST_DBL: begin
        if (r_inf_r) bit_test_s = 1'b1;
        else         state_s    = ST_DBL_W;
      end
      ST_DBL_W: begin
        if (op_done) begin
          r_x_s      = op_rx;
          r_y_s      = op_ry;
          r_inf_s    = op_rinf;
          bit_test_s = 1'b1;
        end else begin
          state_s = ST_DBL_W;
        end
      end
      ST_ADD: begin
        if (r_inf_r) begin
          r_x_s       = p_x_r;
          r_y_s       = p_y_r;
          r_inf_s     = 1'b0;
          take_next_s = 1'b1;
        end else begin
          state_s = ST_ADD_W;
        end
      end
      ST_ADD_W: begin
        if (op_done) begin
          r_x_s       = op_rx;
          r_y_s       = op_ry;
          r_inf_s     = op_rinf;
          take_next_s = 1'b1;
        end else begin
          state_s = ST_ADD_W;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase

    if (bit_test_s) begin
      if (k_r[idx_r]) state_s     = ST_ADD;
      else            take_next_s = 1'b1;
    end else begin
      take_next_s = take_next_s;
    end

    if (take_next_s) begin
      if (idx_r == {IDX_W{1'b0}}) begin
        state_s = ST_DONE;
      end else begin
        idx_s   = idx_r - IDX_W'(1);
        state_s = ST_DBL;
      end
    end else begin
      idx_s = idx_s;
    end
  end

  // Op request decode: registered so op_start is high for the whole DBL/ADD cycle
  always_comb begin
    op_start_s = 1'b0;
    op_sel_s   = op_sel_r;
    if (((state_s == ST_DBL) || (state_s == ST_ADD)) && !r_inf_s) begin
      op_start_s = 1'b1;
      op_sel_s   = (state_s == ST_ADD);
    end else begin
      op_start_s = 1'b0;
    end
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_x_r       <= {DATA_WIDTH{1'b0}};
      p_y_r       <= {DATA_WIDTH{1'b0}};
      k_r         <= {DATA_WIDTH{1'b0}};
      r_x_r       <= {DATA_WIDTH{1'b0}};
      r_y_r       <= {DATA_WIDTH{1'b0}};
      r_inf_r     <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
      rx_r        <= {DATA_WIDTH{1'b0}};
      ry_r        <= {DATA_WIDTH{1'b0}};
      op_start_r  <= 1'b0;
      op_sel_r    <= 1'b0;
      op_ax_r     <= {DATA_WIDTH{1'b0}};
      op_ay_r     <= {DATA_WIDTH{1'b0}};
      op_bx_r     <= {DATA_WIDTH{1'b0}};
      op_by_r     <= {DATA_WIDTH{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && in_valid) begin
        p_x_r <= Px;
        p_y_r <= Py;
        k_r   <= k;
      end
      r_x_r      <= r_x_s;
      r_y_r      <= r_y_s;
      r_inf_r    <= r_inf_s;
      idx_r      <= idx_s;
      op_start_r <= op_start_s;
      op_sel_r   <= op_sel_s;
      // Operands stay frozen between op_start and op_done
      if (op_start_s) begin
        op_ax_r <= r_x_s;
        op_ay_r <= r_y_s;
        op_bx_r <= p_x_r;
        op_by_r <= p_y_r;
      end
      out_valid_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        rx_r <= r_inf_r ? {DATA_WIDTH{1'b0}} : r_x_r;
        ry_r <= r_inf_r ? {DATA_WIDTH{1'b0}} : r_y_r;
      end
    end
  end

endmodule

// File: tb/tb_dp_ctrl.sv
// Self-checking bench for dp_ctrl: mock point unit (latency 3) where DBL/ADD are
// modular doubling/addition, so the reference result is simply k*P mod 2^256.
module tb_dp_ctrl;
  localparam int DW = 256;
  localparam int IW = 8;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] px = '0, py = '0, kk = '0;
  logic          out_valid;
  logic [DW-1:0] rx, ry;
  logic          op_start, op_sel;
  logic [DW-1:0] op_ax, op_ay, op_bx, op_by;
  logic          op_done = 1'b0;
  logic [DW-1:0] op_rx = '0, op_ry = '0;
  logic          op_rinf = 1'b0;

  always #5 clk = ~clk;

  dp_ctrl #(.DATA_WIDTH(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Px(px), .Py(py), .k(kk),
    .out_valid(out_valid), .Rx(rx), .Ry(ry), .op_start(op_start), .op_sel(op_sel),
    .op_ax(op_ax), .op_ay(op_ay), .op_bx(op_bx), .op_by(op_by),
    .op_done(op_done), .op_rx(op_rx), .op_ry(op_ry), .op_rinf(op_rinf)
  );

  int tests = 0, fails = 0;

  typedef struct { logic sel; logic [DW-1:0] ax, ay, bx, by; } op_t;
  op_t log_q[$];

  int            busy_cnt = 0;
  int            inj_inf = 0;
  int            stale_seen = 0;
  logic          aborted = 1'b0;
  logic          m_sel = 1'b0;
  logic [DW-1:0] m_ax = '0, m_ay = '0, m_bx = '0, m_by = '0;

  always @(negedge rst_n) aborted = 1'b1;

  // Mock point unit: logs each op, answers L cycles after op_start
  always begin
    @(posedge clk); #1;
    op_done = 1'b0;
    op_rinf = 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        if (!aborted) begin
          tests++;
          if (op_ax !== m_ax || op_ay !== m_ay || op_bx !== m_bx || op_by !== m_by || op_sel !== m_sel) begin
            fails++;
            $display("FAIL op_hold: operands changed, ax=%h required %h", op_ax, m_ax);
          end
        end else begin
          stale_seen++;
        end
        op_done = 1'b1;
        if (!m_sel && inj_inf != 0) begin
          op_rinf = 1'b1;
          op_rx   = 256'hdead;
          op_ry   = 256'hbeef;
          inj_inf = 0;
        end else if (!m_sel) begin
          op_rx = m_ax << 1;
          op_ry = m_ay << 1;
        end else begin
          op_rx = m_ax + m_bx;
          op_ry = m_ay + m_by;
        end
      end
    end
    if (op_start === 1'b1) begin
      log_q.push_back('{op_sel, op_ax, op_ay, op_bx, op_by});
      m_sel = op_sel; m_ax = op_ax; m_ay = op_ay; m_bx = op_bx; m_by = op_by;
      busy_cnt = L;
      aborted  = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] junk();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int msb_of(input logic [DW-1:0] v);
    int m = -1;
    for (int i = 0; i < DW; i++) if (v[i]) m = i;
    return m;
  endfunction

  function automatic int model_lat(input logic [DW-1:0] kv);
    int m = msb_of(kv);
    if (m <= 0) return 2;
    return 2 + (1 + L) * (m + $countones(kv) - 1);
  endfunction

  // Pulse one request, then wait (bounded) for out_valid
  task automatic do_req(input logic [DW-1:0] k_i, px_i, py_i, output int lat, output logic got);
    in_valid = 1'b1; kk = k_i; px = px_i; py = py_i;
    tick();
    in_valid = 1'b0; kk = junk(); px = junk(); py = junk();
    lat = 0; got = 1'b0;
    while (!got && lat < 5000) begin
      tick(); lat++;
      if (out_valid === 1'b1) got = 1'b1;
    end
  endtask

  // Expected op sequence from double-and-add on multiples of P
  task automatic check_ops(input string name, input logic [DW-1:0] k_i, px_i, py_i);
    logic [DW-1:0] m = 256'd1;
    int n = 0;
    bit ok = 1'b1;
    for (int i = msb_of(k_i) - 1; i >= 0; i--) begin
      if (n >= log_q.size() || log_q[n].sel !== 1'b0 || log_q[n].ax !== m * px_i || log_q[n].ay !== m * py_i) ok = 1'b0;
      n++; m = m << 1;
      if (k_i[i]) begin
        if (n >= log_q.size() || log_q[n].sel !== 1'b1 || log_q[n].ax !== m * px_i || log_q[n].ay !== m * py_i
            || log_q[n].bx !== px_i || log_q[n].by !== py_i) ok = 1'b0;
        n++; m = m + 256'd1;
      end
    end
    tests++;
    if (!ok || n != log_q.size()) begin
      fails++;
      $display("FAIL %s_ops: got %0d ops (content ok=%0d) required %0d ops", name, log_q.size(), ok, n);
    end
  endtask

  task automatic run_check(input string name, input logic [DW-1:0] k_i, px_i, py_i, erx, ery, input int elat);
    int lat; logic got;
    log_q.delete();
    do_req(k_i, px_i, py_i, lat, got);
    check({name, "_valid"}, got, 1'b1);
    check({name, "_rx"}, rx, erx);
    check({name, "_ry"}, ry, ery);
    check({name, "_lat"}, lat, elat);
    tick();
    check({name, "_pulse"}, out_valid, 1'b0);
    check({name, "_hold"}, rx, erx);
    check_ops(name, k_i, px_i, py_i);
  endtask

  typedef struct { logic [DW-1:0] k, px, py, erx, ery; int elat; } vec_t;
  vec_t vecs[7];

  initial begin
    int lat, extra;
    logic got;
    logic [DW-1:0] kr, pxr, pyr;

    vecs[0] = '{256'd0, 256'd5, 256'd7, 256'd0, 256'd0, 2};
    vecs[1] = '{256'd1, 256'h1234, 256'h5678, 256'h1234, 256'h5678, 2};
    vecs[2] = '{256'd3, 256'd11, 256'd13, 256'd33, 256'd39, 10};
    vecs[3] = '{256'd5, 256'd2, 256'd3, 256'd10, 256'd15, 14};
    vecs[4] = '{{1'b1, 255'd0}, 256'd1, 256'd3, {1'b1, 255'd0}, {1'b1, 255'd0}, 1022};
    vecs[5] = '{{DW{1'b1}}, 256'd1, 256'd1, {DW{1'b1}}, {DW{1'b1}}, 2042};
    vecs[6] = '{256'd6, 256'd7, 256'd9, 256'd42, 256'd54, 14};

    tick(); tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_rx", rx, '0);
    check("rst_op_start", op_start, 1'b0);
    check("rst_op_sel", op_sel, 1'b0);
    check("rst_op_ax", op_ax, '0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_check($sformatf("vec%0d", i), vecs[i].k, vecs[i].px, vecs[i].py,
                                          vecs[i].erx, vecs[i].ery, vecs[i].elat);

    for (int i = 0; i < 12; i++) begin
      kr  = junk() >> (DW - $urandom_range(1, 40));
      pxr = junk() | 256'd1;
      pyr = junk() | 256'd1;
      run_check($sformatf("rnd%0d", i), kr, pxr, pyr, kr * pxr, kr * pyr, model_lat(kr));
    end

    // Infinity on the first DBL of k=6: ADD skipped, R=P, then DBL(P)
    log_q.delete();
    inj_inf = 1;
    do_req(256'd6, 256'd7, 256'd9, lat, got);
    check("inf_valid", got, 1'b1);
    check("inf_rx", rx, 256'd14);
    check("inf_ry", ry, 256'd18);
    check("inf_nops", log_q.size(), 2);
    check("inf_op2_dbl_p", (log_q.size() == 2) ? log_q[1].ax : '0, 256'd7);
    tick();

    // in_valid while busy is ignored
    log_q.delete();
    in_valid = 1'b1; kk = 256'd3; px = 256'd11; py = 256'd13;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1; kk = 256'd1; px = 256'd99; py = 256'd98;
    tick();
    in_valid = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 200) begin
      tick(); lat++;
      if (out_valid === 1'b1) got = 1'b1;
    end
    check("busy_valid", got, 1'b1);
    check("busy_rx", rx, 256'd33);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid === 1'b1 || op_start === 1'b1) extra++;
    end
    check("busy_no_extra", extra, 0);
    check("busy_nops", log_q.size(), 2);

    // Reset during DBL_W of k=0xFF; the late op_done must be ignored
    stale_seen = 0;
    in_valid = 1'b1; kk = 256'hff; px = 256'd1; py = 256'd1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_op_start", op_start, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_start", op_start, 1'b0);
    check("mid_rst_ax", op_ax, '0);
    check("mid_rst_rx", rx, '0);
    tick();
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid === 1'b1 || op_start === 1'b1) extra++;
    end
    check("post_rst_quiet", extra, 0);
    check("stale_done_seen", stale_seen, 1);
    run_check("post_rst", 256'd1, 256'hab, 256'hcd, 256'hab, 256'hcd, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
